data_bridge: RTL
================

DATA_BRIDGE -- requirements
Module: data_bridge

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL provide mread  in  mem_pkg::read_req_t  datapath load request: valid, addr[31:0], size (BYTE/HALF/WORD), sign_ext.
REQ-003 SHALL provide mwrite  in  mem_pkg::write_req_t  datapath store request: valid, addr[31:0], size, data[31:0], strobe[3:0].
REQ-004 SHALL provide flush_ex  in  1  cancel the pending request from the datapath.
REQ-005 SHALL provide rd  out  32  load result, aligned and extended.
REQ-006 SHALL provide d_data_ok  out  1  one-cycle completion pulse to the datapath.
REQ-007 SHALL provide the SRAM-like master port: data_req out 1; data_wr out 1; data_size out 2; data_addr out 32; data_wdata out 32; data_addr_ok in 1; data_data_ok in 1; data_rdata in 32.

Function
REQ-008 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE; one outstanding transaction at a time.
REQ-009 IDLE: if mwrite.valid or mread.valid, latch addr/size/data/strobe/sign_ext/byte offset and go to REQ; if both are valid, the write is serviced and the read is ignored.
REQ-010 REQ: data_req=1 with all bus fields driven from latched registers; on data_addr_ok go to WAIT; data_req deasserts in the cycle after addr_ok.
REQ-011 WAIT: on data_data_ok go to IDLE; registered d_data_ok=1 in the following cycle, and for reads rd is updated in that same cycle.
REQ-012 Minimum latency: valid at T0, data_req at T1, addr_ok at T1, data_ok at T2, d_data_ok at T3.
REQ-013 data_wdata SHALL equal mwrite.data replicated per size: byte -> 4 copies, half -> 2 copies, word -> as is; data_size is 0/1/2 for byte/half/word.
REQ-014 Read extraction SHALL select a byte or halfword by addr[1:0] and sign- or zero-extend it per sign_ext; a word read passes through unchanged.
REQ-015 The datapath SHALL hold the request stable until d_data_ok; in IDLE, the block SHALL NOT re-accept the same request during the d_data_ok cycle (IDLE ignores requests while d_data_ok=1).
REQ-016 flush_ex in REQ before addr_ok: drop data_req next cycle, return to IDLE, no d_data_ok.
REQ-017 flush_ex in REQ coincident with addr_ok, or in WAIT: set a kill flag, complete the bus transaction, and suppress d_data_ok and the rd update; the kill flag clears on returning to IDLE.
REQ-018 flush_ex in IDLE SHALL block acceptance of a request in that cycle.
REQ-019 Unaligned addresses are illegal input and are filtered by the exception unit; the block SHALL still pass data_addr through unmodified.
REQ-020 data_data_ok arriving outside WAIT SHALL be ignored.

Reset
REQ-021 On reset the FSM SHALL go to IDLE, and data_req, data_wr, d_data_ok and the kill flag SHALL be 0, with rd=0, data_addr=0, data_wdata=0 and data_size=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it at once; no d_data_ok is emitted afterward.

Structure
REQ-023 read_req_t, write_req_t, the msize_t enum (BYTE=0, HALF=1, WORD=2) and the state enum SHALL live in mem_pkg; word_t SHALL come from common.
REQ-024 Read alignment and extension SHALL be one combinational sub-module, load_align (inputs: rdata, offset, size, sign_ext).
REQ-025 Bus outputs and d_data_ok SHALL be driven from flops only.

Verification
REQ-026 lw at 0x1000 with addr_ok and data_ok immediate and rdata=0xDEADBEEF -> data_req at T1, d_data_ok pulse at T3, rd=0xDEADBEEF.
REQ-027 lb at 0x1003 with sign_ext=1 and rdata=0x80FF_1234 -> rd=0xFFFFFF80; lhu at 0x1002 -> rd=0x000080FF.
REQ-028 sb at 0x2001 with data=0x000000AB and addr_ok delayed 3 cycles -> data_req held 4 cycles, data_wr=1, data_size=0, data_wdata=0xABABABAB, one d_data_ok.
REQ-029 flush_ex in WAIT with data_ok 2 cycles later -> no d_data_ok, rd unchanged, FSM IDLE, next request is accepted normally.
REQ-030 mread and mwrite both valid -> exactly one transaction with data_wr=1; reset asserted in WAIT -> IDLE and all outputs 0 next cycle, with no later pulse.

Source files
------------

// File: rtl/common.sv
// Shared datapath-wide type definitions.
package common;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_pkg.sv
// Types and helpers for the datapath-to-SRAM memory bridge.
package mem_pkg;

    import common::*;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    typedef struct packed {
        logic   valid;
        word_t  addr;
        msize_t size;
        logic   sign_ext;
    } read_req_t;

    typedef struct packed {
        logic       valid;
        word_t      addr;
        msize_t     size;
        word_t      data;
        logic [3:0] strobe;
    } write_req_t;

    // Replicate store data across all byte lanes so the slave can pick the lane from addr.
    function automatic word_t replicate_wdata(input word_t data, input msize_t size);
        case (size)
            BYTE:    return {4{data[7:0]}};
            HALF:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: select byte/halfword by offset and sign- or zero-extend.
module load_align
    import common::*;
    import mem_pkg::*;
(
    input  word_t      rdata,
    input  logic [1:0] offset,
    input  msize_t     size,
    input  logic       sign_ext,
    output word_t      data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension according to access size.
    always_comb begin
        byte_sel = rdata[7:0];
        unique case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            BYTE:    data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            HALF:    data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/data_bridge.sv
// Bridge from datapath load/store requests to an SRAM-like bus, one transaction at a time.
module data_bridge
    import common::*;
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  read_req_t  mread,
    input  write_req_t mwrite,
    input  logic       flush_ex,
    output word_t      rd,
    output logic       d_data_ok,
    output logic       data_req,
    output logic       data_wr,
    output logic [1:0] data_size,
    output word_t      data_addr,
    output word_t      data_wdata,
    input  logic       data_addr_ok,
    input  logic       data_data_ok,
    input  word_t      data_rdata
);

    state_e     state_q, state_d;
    logic       req_q, req_d;
    logic       wr_q, wr_d;
    msize_t     size_q, size_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    logic       sign_ext_q, sign_ext_d;
    logic [1:0] offset_q, offset_d;
    logic       kill_q, kill_d;
    logic       ddok_q, ddok_d;
    word_t      rd_q, rd_d;
    word_t      load_data;

    // Byte lanes are implied by size and address on this bus, so strobe is not forwarded.
    logic unused_strobe;
    assign unused_strobe = ^mwrite.strobe;

    load_align u_load_align (
        .rdata    (data_rdata),
        .offset   (offset_q),
        .size     (size_q),
        .sign_ext (sign_ext_q),
        .data     (load_data)
    );

    // Next-state logic: accept, issue, wait for data, with flush handling.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sign_ext_d = sign_ext_q;
        offset_d   = offset_q;
        kill_d     = kill_q;
        ddok_d     = 1'b0;
        rd_d       = rd_q;

        unique case (state_q)
            StIdle: begin
                kill_d = 1'b0;
                // The request is still held during the completion pulse; don't take it twice.
                if (!ddok_q && !flush_ex && (mwrite.valid || mread.valid)) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    if (mwrite.valid) begin
                        wr_d       = 1'b1;
                        addr_d     = mwrite.addr;
                        size_d     = mwrite.size;
                        wdata_d    = replicate_wdata(mwrite.data, mwrite.size);
                        sign_ext_d = 1'b0;
                        offset_d   = mwrite.addr[1:0];
                    end else begin
                        wr_d       = 1'b0;
                        addr_d     = mread.addr;
                        size_d     = mread.size;
                        sign_ext_d = mread.sign_ext;
                        offset_d   = mread.addr[1:0];
                    end
                end
            end
            StReq: begin
                if (data_addr_ok) begin
                    // Once the address is taken the bus transfer must finish; flush only kills it.
                    state_d = StWait;
                    req_d   = 1'b0;
                    kill_d  = kill_q | flush_ex;
                end else if (flush_ex) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
                end
            end
            StWait: begin
                kill_d = kill_q | flush_ex;
                if (data_data_ok) begin
                    state_d = StIdle;
                    kill_d  = 1'b0;
                    if (!(kill_q || flush_ex)) begin
                        ddok_d = 1'b1;
                        if (!wr_q) begin
                            rd_d = load_data;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            sign_ext_q <= 1'b0;
            offset_q   <= 2'd0;
            kill_q     <= 1'b0;
            ddok_q     <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sign_ext_q <= sign_ext_d;
            offset_q   <= offset_d;
            kill_q     <= kill_d;
            ddok_q     <= ddok_d;
            rd_q       <= rd_d;
        end
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign d_data_ok  = ddok_q;
    assign rd         = rd_q;

endmodule
